wide_sub_seq: RTL and testbench

Multi-cycle sequencer that computes a WORDS*N-bit borrow subtraction D = A - B - BIN. It time-shares a single N-bit borrow-chain slice, Nbit_FullAdder with port order (D, BO, A, B, BI). One N-bit word is processed per cycle, LSW first, and the borrow is registered between words. It sits in the FPU integer/exponent path wherever a wide subtract is needed without a wide combinational chain.

---
 rtl/wide_sub_seq_pkg.sv | 16 +
 rtl/wide_sub_seq_if.sv | 28 ++
 rtl/wide_sub_seq_nbit_fulladder.sv | 15 +
 rtl/wide_sub_seq.sv | 147 ++++++++++++++
 tb/tb_wide_sub_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wide_sub_seq_pkg.sv
// Shared types and helpers for the wide_sub_seq sequencer.
// Holds the FSM state encoding and the word-index width calculation.
package wide_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } wide_sub_state_t;

  // Width of the word-index counter: clog2(words), never narrower than 1 bit.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_sub_seq_if.sv
// Operand/result handshake bundle for wide_sub_seq.
// The master side supplies operands and consumes results; the slave side is the sequencer.
interface wide_sub_seq_if #(
  parameter int W = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, busy
  );

endinterface

// File: rtl/wide_sub_seq_nbit_fulladder.sv
// N-bit borrow-chain slice: D = A - B - BI, BO set when the slice borrows out.
module Nbit_FullAdder #(
  parameter int N = 8
) (
  output logic [N-1:0] D,
  output logic         BO,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         BI
);

  // One extra bit on top of the slice captures the borrow out of the MSB.
  assign {BO, D} = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, BI};

endmodule

// File: rtl/wide_sub_seq.sv
// Multi-cycle wide subtractor: D = A - B - BIN over WORDS passes of one N-bit slice.
// Words are processed LSW first with the borrow registered between passes.
// Optional macro WIDE_SUB_SEQ_BACK2BACK_EN lets DONE hand off straight to RUN
// when a result is retired and new operands arrive in the same cycle.
module wide_sub_seq
  import wide_sub_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic clk,
  input  logic rst_n,
  wide_sub_seq_if.slave bus
);

  localparam int            IW       = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  wide_sub_state_t state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic            bout_q, bout_d;

  // Operands and result viewed as WORDS slices of N bits, word 0 is the LSW.
  logic [WORDS-1:0][N-1:0] a_q, a_d;
  logic [WORDS-1:0][N-1:0] b_q, b_d;
  logic [WORDS-1:0][N-1:0] d_q, d_d;

  logic [N-1:0] slice_d;
  logic         slice_bo;

  logic in_ready;
  logic out_valid;
  logic busy;

  // The single shared slice always works on the word selected by idx_q.
  Nbit_FullAdder #(
    .N(N)
  ) u_slice (
    .D (slice_d),
    .BO(slice_bo),
    .A (a_q[idx_q]),
    .B (b_q[idx_q]),
    .BI(borrow_q)
  );

  // Next-state, handshake and datapath update for IDLE/RUN/DONE.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    bout_d    = bout_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        busy       = 1'b1;
        d_d[idx_q] = slice_d;
        borrow_d   = slice_bo;
        if (idx_q == LAST_IDX) begin
          // Park the counter at 0 rather than stepping past the last word.
          bout_d  = slice_bo;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
`ifdef WIDE_SUB_SEQ_BACK2BACK_EN
        in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            a_d      = bus.a;
            b_d      = bus.b;
            borrow_d = bus.bin;
            idx_d    = '0;
            state_d  = RUN;
          end else begin
            state_d = IDLE;
          end
        end
`else
        if (bus.out_ready) begin
          state_d = IDLE;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      d_q      <= d_d;
    end
  end

  // Operand capture registers, loaded only on accept.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are not reset; they are always written on accept before RUN reads them.
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_wide_sub_seq.sv
// Self-checking bench for wide_sub_seq: a WORDS=4 and a WORDS=1 instance side by side,
// directed corner cases, backpressure, mid-run reset, throughput and a random sweep
// against the plain arithmetic golden {bout,d} = {0,a} - {0,b} - bin.
module tb_wide_sub_seq;

  localparam int N      = 8;
  localparam int WORDS  = 4;
  localparam int W      = N * WORDS;
  localparam int W1     = N;
`ifdef WIDE_SUB_SEQ_BACK2BACK_EN
  localparam int PERIOD = WORDS + 1;
`else
  localparam int PERIOD = WORDS + 2;
`endif

  logic clk;
  logic rst_n;

  int tests = 0;
  int fails = 0;

  wide_sub_seq_if #(.W(W))  bus4 ();
  wide_sub_seq_if #(.W(W1)) bus1 ();

  wide_sub_seq #(.N(N), .WORDS(WORDS)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  wide_sub_seq #(.N(N), .WORDS(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WORDS=4 instance, checked against the golden model.
  task automatic run_op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input string tag);
    logic [W:0] exp;
    int n;
    exp = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    n = 0;
    while (bus4.in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, " in_ready"}, 64'(bus4.in_ready), 64'd1);
    bus4.in_valid = 1'b1;
    bus4.a        = a;
    bus4.b        = b;
    bus4.bin      = bin;
    tick();
    bus4.in_valid = 1'b0;
    n = 0;
    while (bus4.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, " latency"}, 64'(n), 64'(WORDS));
    check({tag, " d"}, 64'(bus4.d), 64'(exp[W-1:0]));
    check({tag, " bout"}, 64'(bus4.bout), 64'(exp[W]));
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check({tag, " out_valid fall"}, 64'(bus4.out_valid), 64'd0);
  endtask

  // One full transaction on the WORDS=1 instance.
  task automatic run_op1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic bin, input string tag);
    logic [W1:0] exp;
    int n;
    exp = {1'b0, a} - {1'b0, b} - (W1+1)'(bin);
    n = 0;
    while (bus1.in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, " in_ready"}, 64'(bus1.in_ready), 64'd1);
    bus1.in_valid = 1'b1;
    bus1.a        = a;
    bus1.b        = b;
    bus1.bin      = bin;
    tick();
    bus1.in_valid = 1'b0;
    n = 0;
    while (bus1.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, " latency"}, 64'(n), 64'd1);
    check({tag, " d"}, 64'(bus1.d), 64'(exp[W1-1:0]));
    check({tag, " bout"}, 64'(bus1.bout), 64'(exp[W1]));
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] da [5];
    logic [W-1:0] db [5];
    logic         dbin [5];
    logic [W-1:0] ra, rb, hold_d;
    logic [W:0]   exp;
    logic         seen;
    int           hits [4];
    int           nhits, n;

    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0; bus1.out_ready = 1'b0;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset in_ready",  64'(bus4.in_ready),  64'd1);
    check("reset out_valid", 64'(bus4.out_valid), 64'd0);
    check("reset busy",      64'(bus4.busy),      64'd0);
    check("reset d",         64'(bus4.d),         64'd0);
    check("reset bout",      64'(bus4.bout),      64'd0);
    check("reset1 d",        64'(bus1.d),         64'd0);

    // Directed corner cases, including cross-word borrow propagation
    da[0] = 32'd10;          db[0] = 32'd4;           dbin[0] = 1'b1;
    da[1] = 32'd4;           db[1] = 32'd10;          dbin[1] = 1'b0;
    da[2] = 32'd0;           db[2] = 32'd0;           dbin[2] = 1'b1;
    da[3] = 32'h0001_0000;   db[3] = 32'd1;           dbin[3] = 1'b0;
    da[4] = 32'h8000_0000;   db[4] = 32'h7FFF_FFFF;   dbin[4] = 1'b0;
    for (int i = 0; i < 5; i++) run_op4(da[i], db[i], dbin[i], $sformatf("dir%0d", i));

    // Literal spot checks of known results
    run_op4(32'd0, 32'd0, 1'b1, "all_ones");
    check("all_ones literal d", 64'(bus4.d), 64'h0000_0000_FFFF_FFFF);
    run_op4(32'h0001_0000, 32'd1, 1'b0, "xword");
    check("xword literal d", 64'(bus4.d), 64'h0000_0000_0000_FFFF);

    // Backpressure: result held in DONE while a new request waits
    bus4.in_valid = 1'b1; bus4.a = 32'h1234_5678; bus4.b = 32'h0000_1111; bus4.bin = 1'b0;
    tick();
    bus4.in_valid = 1'b0;
    n = 0;
    while (bus4.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check("bp latency", 64'(n), 64'(WORDS));
    bus4.in_valid = 1'b1; bus4.a = 32'hFFFF_FFFF; bus4.b = 32'd0; bus4.bin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp out_valid %0d", i), 64'(bus4.out_valid), 64'd1);
      check($sformatf("bp d %0d", i),         64'(bus4.d),         64'h1234_4567);
      check($sformatf("bp bout %0d", i),      64'(bus4.bout),      64'd0);
      check($sformatf("bp in_ready %0d", i),  64'(bus4.in_ready),  64'd0);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check("bp release out_valid", 64'(bus4.out_valid), 64'd0);
    check("bp release busy",      64'(bus4.busy),      64'd0);
    check("bp release in_ready",  64'(bus4.in_ready),  64'd1);
    check("bp d held in idle",    64'(bus4.d),         64'h1234_4567);

    // Reset in the middle of RUN (idx=2)
    bus4.in_valid = 1'b1; bus4.a = 32'hDEAD_BEEF; bus4.b = 32'd1; bus4.bin = 1'b0;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst out_valid", 64'(bus4.out_valid), 64'd0);
    check("midrst d",         64'(bus4.d),         64'd0);
    check("midrst bout",      64'(bus4.bout),      64'd0);
    check("midrst in_ready",  64'(bus4.in_ready),  64'd1);
    check("midrst busy",      64'(bus4.busy),      64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus4.out_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst no pulse", 64'(seen), 64'd0);
    run_op4(32'd200, 32'd100, 1'b0, "post_rst");

    // Throughput with in_valid and out_ready held high
    bus4.a = 32'h0F0F_0F0F; bus4.b = 32'h1111_1111; bus4.bin = 1'b1;
    exp = {1'b0, bus4.a} - {1'b0, bus4.b} - 33'd1;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    nhits = 0;
    for (int i = 0; i < 40 && nhits < 4; i++) begin
      tick();
      if (bus4.out_valid === 1'b1) begin
        hits[nhits] = cyc;
        check($sformatf("tput d %0d", nhits), 64'(bus4.d), 64'(exp[W-1:0]));
        nhits++;
      end
    end
    check("tput results", 64'(nhits), 64'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < nhits) check($sformatf("tput period %0d", i), 64'(hits[i] - hits[i-1]), 64'(PERIOD));
    end
    bus4.in_valid = 1'b0;
    n = 0;
    while (bus4.busy !== 1'b0 && n < 20) begin tick(); n++; end
    bus4.out_ready = 1'b0;
    check("tput drained", 64'(bus4.busy), 64'd0);

    // WORDS=1 instance: directed cases
    run_op1(8'd10, 8'd4, 1'b1, "w1 dir0");
    check("w1 dir0 literal d", 64'(bus1.d), 64'd5);
    run_op1(8'd0, 8'd0, 1'b1, "w1 dir1");
    check("w1 dir1 literal d", 64'(bus1.d), 64'hFF);
    check("w1 dir1 literal bout", 64'(bus1.bout), 64'd1);

    // Random sweep on the WORDS=4 instance
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
      run_op4(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Random sweep on the WORDS=1 instance
    for (int i = 0; i < 300; i++) begin
      run_op1(W1'($urandom), W1'($urandom), 1'($urandom_range(0, 1)), $sformatf("w1rnd%0d", i));
    end

    hold_d = bus4.d;
    tick();
    check("final d hold", 64'(bus4.d), 64'(hold_d));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
